// File: rtl/instr_mem_prog.sv
// Loadable instruction memory: a loader port fills the program, a fixed-latency
// read port serves fetches. Unwritten or faulting fetches return FILL_WORD.
module instr_mem_prog #(
    parameter int          ADDR_W    = 32,
    parameter int          DEPTH     = 256,
    parameter bit          BYTE_ADDR = 1'b1,
    parameter int          READ_LAT  = 1,
    parameter logic [31:0] FILL_WORD = 32'h0000_0000,
    localparam int         IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              rd_fault,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              ld_start,
    output logic              prog_rdy
);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_t;

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prog_rdy;
    logic              w_accept;
    logic              w_clear;
    logic [DEPTH-1:0]  r_written;
    logic [31:0]       r_mem [DEPTH];

    logic [ADDR_W-1:0] w_word_addr;
    logic [IDX_W-1:0]  w_idx;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_fault;
    logic [31:0]       w_fetch_data;

    logic              r_v1;
    logic [31:0]       r_d1;
    logic              r_f1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_prog_rdy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prog_rdy <= (w_state_nxt == S_RUN);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_clear     = 1'b0;
        if (ld_start) begin
            w_state_nxt = S_EMPTY;
            w_clear     = 1'b1;
        end else if (ld_valid && (r_state != S_RUN)) begin
            w_accept    = 1'b1;
            w_state_nxt = ld_last ? S_RUN : S_LOAD;
        end
    end

    assign ld_ready = (r_state != S_RUN);
    assign prog_rdy = r_prog_rdy;

    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_written <= '0;
        end else if (w_accept) begin
            r_written[ld_addr] <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the written bitmap masks stale contents to FILL_WORD.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    assign w_word_addr    = BYTE_ADDR ? (rd_addr >> 2) : rd_addr;
    assign w_idx          = w_word_addr[IDX_W-1:0];
    assign w_misaligned   = BYTE_ADDR && (rd_addr[1:0] != 2'b00);
    assign w_out_of_range = ({1'b0, w_word_addr} >= DEPTH_X);
    assign w_fault        = w_misaligned || w_out_of_range || (r_state != S_RUN);
    assign w_fetch_data   = (!w_fault && r_written[w_idx]) ? r_mem[w_idx] : FILL_WORD;

    // The response is resolved at issue; later stages only carry it forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_d1 <= FILL_WORD;
            r_f1 <= 1'b0;
        end else begin
            r_v1 <= rd_req;
            r_d1 <= rd_req ? w_fetch_data : FILL_WORD;
            r_f1 <= rd_req && w_fault;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic        r_v2;
            logic [31:0] r_d2;
            logic        r_f2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v2 <= 1'b0;
                    r_d2 <= FILL_WORD;
                    r_f2 <= 1'b0;
                end else begin
                    r_v2 <= r_v1;
                    r_d2 <= r_d1;
                    r_f2 <= r_f1;
                end
            end

            assign rd_valid = r_v2;
            assign rd_data  = r_d2;
            assign rd_fault = r_f2;
        end else begin : g_lat1
            assign rd_valid = r_v1;
            assign rd_data  = r_d1;
            assign rd_fault = r_f1;
        end
    endgenerate

endmodule

// File: tb/tb_instr_mem_prog.sv
// Self-checking bench: two instances (byte/lat1 and word/lat2) share stimulus and
// are compared against an abstract program/fetch model kept here.
module tb_instr_mem_prog;

    localparam logic [31:0] FILL0 = 32'h0000_0000;
    localparam logic [31:0] FILL1 = 32'h0BAD_0BAD;
    localparam int          DEPTH = 256;

    typedef enum {M_EMPTY, M_LOAD, M_RUN} mstate_t;
    typedef struct {
        longint      due;
        logic [31:0] data;
        logic        fault;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst, rd_req, ld_valid, ld_last, ld_start;
    logic [31:0] rd_addr, ld_data;
    logic [7:0]  ld_addr;

    logic        rd_valid [2];
    logic [31:0] rd_data  [2];
    logic        rd_fault [2];
    logic        ld_ready [2];
    logic        prog_rdy [2];

    always #5 clk = ~clk;

    instr_mem_prog #(
        .ADDR_W(32), .DEPTH(DEPTH), .BYTE_ADDR(1'b1), .READ_LAT(1), .FILL_WORD(FILL0)
    ) dut0 (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_fault(rd_fault[0]),
        .ld_valid(ld_valid), .ld_ready(ld_ready[0]), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .ld_start(ld_start), .prog_rdy(prog_rdy[0])
    );

    instr_mem_prog #(
        .ADDR_W(32), .DEPTH(DEPTH), .BYTE_ADDR(1'b0), .READ_LAT(2), .FILL_WORD(FILL1)
    ) dut1 (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_fault(rd_fault[1]),
        .ld_valid(ld_valid), .ld_ready(ld_ready[1]), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .ld_start(ld_start), .prog_rdy(prog_rdy[1])
    );

    // Reference model: program state, written flags and contents, expected responses.
    mstate_t     m_state;
    bit          m_written [DEPTH];
    logic [31:0] m_mem     [DEPTH];
    resp_t       q0 [$];
    resp_t       q1 [$];
    longint      cyc     = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fill_of(input int u);
        return (u == 0) ? FILL0 : FILL1;
    endfunction

    function automatic resp_t predict(input int u, input logic [31:0] a);
        resp_t  r;
        bit     byte_mode = (u == 0);
        longint word      = byte_mode ? longint'(a >> 2) : longint'(a);
        bit     mis       = byte_mode && (a[1:0] != 2'b00);
        bit     oor       = (word >= DEPTH);
        r.due   = cyc + ((u == 0) ? 0 : 1);
        r.fault = mis || oor || (m_state != M_RUN);
        r.data  = fill_of(u);
        if (!r.fault && m_written[int'(word)]) r.data = m_mem[int'(word)];
        return r;
    endfunction

    task automatic model_edge();
        cyc++;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_state = M_EMPTY;
            foreach (m_written[i]) m_written[i] = 1'b0;
            return;
        end
        if (rd_req) begin
            q0.push_back(predict(0, rd_addr));
            q1.push_back(predict(1, rd_addr));
        end
        if (ld_start) begin
            m_state = M_EMPTY;
            foreach (m_written[i]) m_written[i] = 1'b0;
        end else if (ld_valid && m_state != M_RUN) begin
            m_mem[ld_addr]     = ld_data;
            m_written[ld_addr] = 1'b1;
            m_state            = ld_last ? M_RUN : M_LOAD;
        end
    endtask

    task automatic check_outputs();
        for (int u = 0; u < 2; u++) begin
            resp_t e;
            bit    ev;
            e.data  = fill_of(u);
            e.fault = 1'b0;
            e.due   = 0;
            if (u == 0) begin
                ev = (q0.size() != 0) && (q0[0].due == cyc);
                if (ev) e = q0.pop_front();
            end else begin
                ev = (q1.size() != 0) && (q1[0].due == cyc);
                if (ev) e = q1.pop_front();
            end
            check($sformatf("u%0d rd_valid", u), {31'b0, rd_valid[u]}, {31'b0, ev});
            check($sformatf("u%0d rd_data", u), rd_data[u], e.data);
            check($sformatf("u%0d rd_fault", u), {31'b0, rd_fault[u]}, {31'b0, e.fault});
            check($sformatf("u%0d ld_ready", u), {31'b0, ld_ready[u]}, {31'b0, m_state != M_RUN});
            check($sformatf("u%0d prog_rdy", u), {31'b0, prog_rdy[u]}, {31'b0, m_state == M_RUN});
        end
    endtask

    task automatic idle_inputs();
        rd_req   = 1'b0;
        rd_addr  = 32'h0;
        ld_valid = 1'b0;
        ld_addr  = 8'h0;
        ld_data  = 32'h0;
        ld_last  = 1'b0;
        ld_start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        idle_inputs();
    endtask

    task automatic fetch(input logic [31:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_last  = last;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        foreach (m_mem[i]) m_mem[i] = 32'h0;
        foreach (m_written[i]) m_written[i] = 1'b0;
        m_state = M_EMPTY;
        idle_inputs();

        rst = 1'b1;
        idle(2);
        rst = 1'b0;

        // Fetch before any program is loaded.
        fetch(32'h0);
        idle(2);

        // Two-word program, then back-to-back fetches.
        load(8'd0, 32'h0800_0004, 1'b0);
        load(8'd1, 32'h1232_0001, 1'b1);
        idle(1);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        idle(2);

        // Misaligned, just past the end, and top of the address space.
        fetch(32'h2);
        fetch(32'h400);
        fetch(32'h3FC);
        fetch(32'h100);
        fetch(32'hFFFF_FFFC);
        idle(2);

        // Fetch in the same cycle as ld_start, then again after.
        rd_req   = 1'b1;
        rd_addr  = 32'h0;
        ld_start = 1'b1;
        tick();
        fetch(32'h0);
        fetch(32'h1);
        idle(2);

        // Reload, then reset with fetches still in flight.
        load(8'd0, 32'hAAAA_0000, 1'b0);
        load(8'd1, 32'hBBBB_0001, 1'b1);
        fetch(32'h0);
        fetch(32'h1);
        fetch(32'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);

        // Word-addressed load at index 4; loader beats in RUN are ignored.
        load(8'd4, 32'h0285_C022, 1'b1);
        fetch(32'h4);
        fetch(32'h10);
        load(8'd4, 32'h1111_1111, 1'b1);
        fetch(32'h4);
        fetch(32'h10);
        idle(3);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            int sel;
            rst      = ($urandom_range(0, 299) == 0);
            ld_start = ($urandom_range(0, 59) == 0);
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_addr  = 8'($urandom_range(0, 15));
            ld_data  = $urandom;
            ld_last  = ($urandom_range(0, 9) == 0);
            rd_req   = ($urandom_range(0, 2) != 0);
            sel      = $urandom_range(0, 6);
            case (sel)
                0, 1:    rd_addr = 32'($urandom_range(0, 63));
                2:       rd_addr = 32'($urandom_range(0, 15)) << 2;
                3:       rd_addr = $urandom;
                4:       rd_addr = 32'hFFFF_FFFC;
                5:       rd_addr = 32'h3FC + 32'($urandom_range(0, 8));
                default: rd_addr = 32'h0FF + 32'($urandom_range(0, 1));
            endcase
            tick();
        end
        rst = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
